// File: rtl/i2s_tx_sequencer.sv
// -----------------------------------------------------------------------------
// i2s_tx_sequencer
// Frame-level controller for a 24-bit, two-channel I2S transmit encoder.
// It divides the system clock down to BCLK, derives LRCLK from a bit counter,
// and once per frame grants one stereo source. src1 (sidetone) has priority
// over src0 (receiver audio). The granted pair is held on the outputs for the
// whole frame. Frames with no valid source are counted as underruns.
//
// Build option: define I2S_SEQ_UNDERRUN_HOLD_EN to repeat the previous pair on
// an underrun frame. By default an underrun frame outputs silence (zeros).
//
// Ports:
//   clock, nreset          system clock, asynchronous active-low reset
//   enable                 run sequencer; low forces the clock generators idle
//   src0_left/right/valid  receiver audio pair and its valid flag
//   src0_ready             one-cycle take strobe to src0
//   src1_left/right/valid  sidetone pair and its valid flag
//   src1_ready             one-cycle take strobe to src1
//   BCLK, LRCLK            bit clock and word select (low = left slot)
//   left_sample/right_sample  pair to encoder, stable for a whole frame
//   src_sel                source of the current pair (0 = src0, 1 = src1)
//   frame_start            one-cycle pulse in the cycle LRCLK falls
//   underrun_count         saturating count of frames with no source valid
// -----------------------------------------------------------------------------
module i2s_tx_sequencer #(
   parameter int unsigned CLK_DIV   = 20,
   parameter int unsigned SLOT_BITS = 32
) (
   input  logic        clock,
   input  logic        nreset,
   input  logic        enable,
   input  logic [23:0] src0_left,
   input  logic [23:0] src0_right,
   input  logic        src0_valid,
   output logic        src0_ready,
   input  logic [23:0] src1_left,
   input  logic [23:0] src1_right,
   input  logic        src1_valid,
   output logic        src1_ready,
   output logic        BCLK,
   output logic        LRCLK,
   output logic [23:0] left_sample,
   output logic [23:0] right_sample,
   output logic        src_sel,
   output logic        frame_start,
   output logic [7:0]  underrun_count
);

   localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
   localparam int unsigned DIV_W      = $clog2(CLK_DIV);
   localparam int unsigned BIT_W      = $clog2(FRAME_BITS);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
   localparam logic [BIT_W-1:0] BIT_SLOT = BIT_W'(SLOT_BITS);

   logic [DIV_W-1:0] r_div_cnt,  w_div_nxt;
   logic [BIT_W-1:0] r_bit_cnt,  w_bit_nxt;
   logic             r_bclk,     w_bclk_nxt;
   logic             r_lrclk,    w_lrclk_nxt;
   logic [23:0]      r_left,     w_left_nxt;
   logic [23:0]      r_right,    w_right_nxt;
   logic             r_src_sel,  w_src_sel_nxt;
   logic [7:0]       r_underrun, w_underrun_nxt;

   logic             w_div_wrap;
   logic [BIT_W-1:0] w_bit_inc;
   logic             w_boundary;
   logic             w_take0;
   logic             w_take1;
   logic             w_underrun;

   assign w_div_wrap = (r_div_cnt == DIV_LAST);
   assign w_bit_inc  = (r_bit_cnt == BIT_LAST) ? '0 : r_bit_cnt + BIT_W'(1);

   // The boundary is the BCLK falling toggle that wraps bit_cnt to 0. Valids are
   // only looked at here, and the grant lands on this same clock edge.
   assign w_boundary = enable && w_div_wrap && r_bclk && (r_bit_cnt == BIT_LAST);
   assign w_take1    = w_boundary && src1_valid;
   assign w_take0    = w_boundary && !src1_valid && src0_valid;
   assign w_underrun = w_boundary && !src1_valid && !src0_valid;

   always_comb begin
      w_div_nxt      = r_div_cnt;
      w_bit_nxt      = r_bit_cnt;
      w_bclk_nxt     = r_bclk;
      w_lrclk_nxt    = r_lrclk;
      w_left_nxt     = r_left;
      w_right_nxt    = r_right;
      w_src_sel_nxt  = r_src_sel;
      w_underrun_nxt = r_underrun;

      if (!enable) begin
         w_div_nxt   = '0;
         w_bit_nxt   = BIT_LAST;
         w_bclk_nxt  = 1'b0;
         w_lrclk_nxt = 1'b1;
      end else begin
         w_div_nxt = w_div_wrap ? '0 : r_div_cnt + DIV_W'(1);
         if (w_div_wrap) begin
            w_bclk_nxt = ~r_bclk;
            // LRCLK only moves together with a falling BCLK
            if (r_bclk) begin
               w_bit_nxt   = w_bit_inc;
               w_lrclk_nxt = (w_bit_inc >= BIT_SLOT);
            end
         end
      end

      if (w_take1) begin
         w_left_nxt    = src1_left;
         w_right_nxt   = src1_right;
         w_src_sel_nxt = 1'b1;
      end else if (w_take0) begin
         w_left_nxt    = src0_left;
         w_right_nxt   = src0_right;
         w_src_sel_nxt = 1'b0;
      end else if (w_underrun) begin
`ifdef I2S_SEQ_UNDERRUN_HOLD_EN
         w_left_nxt  = r_left;
         w_right_nxt = r_right;
`else
         w_left_nxt  = 24'h000000;
         w_right_nxt = 24'h000000;
`endif
         if (r_underrun != 8'hFF) begin
            w_underrun_nxt = r_underrun + 8'd1;
         end
      end
   end

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         r_div_cnt  <= '0;
         r_bit_cnt  <= BIT_LAST;
         r_bclk     <= 1'b0;
         r_lrclk    <= 1'b1;
         r_left     <= 24'h000000;
         r_right    <= 24'h000000;
         r_src_sel  <= 1'b0;
         r_underrun <= 8'd0;
      end else begin
         r_div_cnt  <= w_div_nxt;
         r_bit_cnt  <= w_bit_nxt;
         r_bclk     <= w_bclk_nxt;
         r_lrclk    <= w_lrclk_nxt;
         r_left     <= w_left_nxt;
         r_right    <= w_right_nxt;
         r_src_sel  <= w_src_sel_nxt;
         r_underrun <= w_underrun_nxt;
      end
   end

   assign src0_ready     = w_take0;
   assign src1_ready     = w_take1;
   assign frame_start    = w_boundary;
   assign BCLK           = r_bclk;
   assign LRCLK          = r_lrclk;
   assign left_sample    = r_left;
   assign right_sample   = r_right;
   assign src_sel        = r_src_sel;
   assign underrun_count = r_underrun;

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// -----------------------------------------------------------------------------
// tb_i2s_tx_sequencer
// Self-checking bench for i2s_tx_sequencer with CLK_DIV=2, SLOT_BITS=32.
// The reference model tracks only the number of running clock edges since the
// last reset/enable and derives BCLK, LRCLK and frame boundaries arithmetically
// from it; the sample pair, source select and underrun count follow the
// arbitration rules. Honours I2S_SEQ_UNDERRUN_HOLD_EN like the design.
// -----------------------------------------------------------------------------
module tb_i2s_tx_sequencer;

   localparam int unsigned CLK_DIV    = 2;
   localparam int unsigned SLOT_BITS  = 32;
   localparam int unsigned BCLK_CLKS  = 2 * CLK_DIV;
   localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
   localparam int unsigned FRAME_CLKS = BCLK_CLKS * FRAME_BITS;

   logic        clock  = 1'b0;
   logic        nreset = 1'b1;
   logic        enable = 1'b0;
   logic [23:0] src0_left  = '0;
   logic [23:0] src0_right = '0;
   logic        src0_valid = 1'b0;
   logic        src0_ready;
   logic [23:0] src1_left  = '0;
   logic [23:0] src1_right = '0;
   logic        src1_valid = 1'b0;
   logic        src1_ready;
   logic        BCLK;
   logic        LRCLK;
   logic [23:0] left_sample;
   logic [23:0] right_sample;
   logic        src_sel;
   logic        frame_start;
   logic [7:0]  underrun_count;

   always #5 clock = ~clock;

   i2s_tx_sequencer #(
      .CLK_DIV   (CLK_DIV),
      .SLOT_BITS (SLOT_BITS)
   ) u_dut (
      .clock          (clock),
      .nreset         (nreset),
      .enable         (enable),
      .src0_left      (src0_left),
      .src0_right     (src0_right),
      .src0_valid     (src0_valid),
      .src0_ready     (src0_ready),
      .src1_left      (src1_left),
      .src1_right     (src1_right),
      .src1_valid     (src1_valid),
      .src1_ready     (src1_ready),
      .BCLK           (BCLK),
      .LRCLK          (LRCLK),
      .left_sample    (left_sample),
      .right_sample   (right_sample),
      .src_sel        (src_sel),
      .frame_start    (frame_start),
      .underrun_count (underrun_count)
   );

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   // Reference model state
   int unsigned m_k = 0;        // running clock edges since reset/enable
   logic [23:0] m_left  = '0;
   logic [23:0] m_right = '0;
   logic        m_sel   = 1'b0;
   int unsigned m_cnt   = 0;

   // Requested input values for the next cycle
   logic        d_nrst = 1'b0;
   logic        d_en   = 1'b0;
   logic        d_v0   = 1'b0;
   logic        d_v1   = 1'b0;
   logic [23:0] d_l0   = '0;
   logic [23:0] d_r0   = '0;
   logic [23:0] d_l1   = '0;
   logic [23:0] d_r1   = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic logic exp_bclk(input int unsigned k);
      return ((k / CLK_DIV) % 2) == 1;
   endfunction

   function automatic logic exp_lrclk(input int unsigned k);
      int unsigned f;
      f = k / BCLK_CLKS;
      if (f == 0) return 1'b1;
      return ((f - 1) % FRAME_BITS) >= SLOT_BITS;
   endfunction

   // True when the edge ending cycle k makes the bit position wrap to 0
   function automatic logic is_boundary(input int unsigned k);
      if ((k + 1) % BCLK_CLKS != 0) return 1'b0;
      return (((k + 1) / BCLK_CLKS - 1) % FRAME_BITS) == 0;
   endfunction

   function automatic int unsigned bit_pos(input int unsigned k);
      if (k < BCLK_CLKS) return FRAME_BITS - 1;
      return (k / BCLK_CLKS - 1) % FRAME_BITS;
   endfunction

   task automatic run_cycle();
      logic run;
      logic bnd;
      logic e_r0;
      logic e_r1;
      @(posedge clock);
      #1;
      nreset     = d_nrst;
      enable     = d_en;
      src0_valid = d_v0;
      src0_left  = d_l0;
      src0_right = d_r0;
      src1_valid = d_v1;
      src1_left  = d_l1;
      src1_right = d_r1;
      if (!d_nrst) begin
         m_k = 0; m_left = '0; m_right = '0; m_sel = 1'b0; m_cnt = 0;
      end
      @(negedge clock);
      run  = d_nrst && d_en;
      bnd  = run && is_boundary(m_k);
      e_r1 = bnd && d_v1;
      e_r0 = bnd && !d_v1 && d_v0;
      check("bclk",        32'(BCLK),           32'(exp_bclk(m_k)));
      check("lrclk",       32'(LRCLK),          32'(exp_lrclk(m_k)));
      check("frame_start", 32'(frame_start),    32'(bnd));
      check("src0_ready",  32'(src0_ready),     32'(e_r0));
      check("src1_ready",  32'(src1_ready),     32'(e_r1));
      check("left",        32'(left_sample),    32'(m_left));
      check("right",       32'(right_sample),   32'(m_right));
      check("src_sel",     32'(src_sel),        32'(m_sel));
      check("underruns",   32'(underrun_count), m_cnt);
      if (run) begin
         if (bnd) begin
            if (d_v1) begin
               m_left = d_l1; m_right = d_r1; m_sel = 1'b1;
            end else if (d_v0) begin
               m_left = d_l0; m_right = d_r0; m_sel = 1'b0;
            end else begin
`ifndef I2S_SEQ_UNDERRUN_HOLD_EN
               m_left = '0; m_right = '0;
`endif
               if (m_cnt < 255) m_cnt++;
            end
         end
         m_k++;
      end else begin
         m_k = 0;
      end
   endtask

   task automatic do_reset();
      d_nrst = 1'b0;
      repeat (2) run_cycle();
      d_nrst = 1'b1;
   endtask

   initial begin
      nreset = 1'b0;
      do_reset();
      check("rst_underruns", 32'(underrun_count), 32'd0);
      check("rst_lrclk",     32'(LRCLK),          32'd1);

      // Idle frames with no source: every frame is an underrun
      d_en = 1'b1;
      repeat (3 * FRAME_CLKS) run_cycle();
      check("idle_underruns", 32'(underrun_count), 32'd3);
      check("idle_left",      32'(left_sample),    32'd0);

      // src0 only
      d_v0 = 1'b1; d_l0 = 24'h123456; d_r0 = 24'hABCDEF;
      repeat (3 * FRAME_CLKS) run_cycle();
      check("src0_left",  32'(left_sample),  32'h123456);
      check("src0_right", 32'(right_sample), 32'hABCDEF);
      check("src0_sel",   32'(src_sel),      32'd0);

      // Both valid: src1 wins
      d_v1 = 1'b1; d_l1 = 24'h7FFFFF; d_r1 = 24'h800000;
      repeat (2 * FRAME_CLKS) run_cycle();
      check("src1_left",  32'(left_sample),  32'h7FFFFF);
      check("src1_right", 32'(right_sample), 32'h800000);
      check("src1_sel",   32'(src_sel),      32'd1);

      // One frame of src0, then starve
      d_v1 = 1'b0; d_v0 = 1'b1; d_l0 = 24'h000001; d_r0 = 24'h000001;
      do_reset();
      repeat (FRAME_CLKS) run_cycle();
      d_v0 = 1'b0;
      repeat (FRAME_CLKS) run_cycle();
      check("starve_underruns", 32'(underrun_count), 32'd1);
`ifdef I2S_SEQ_UNDERRUN_HOLD_EN
      check("starve_left", 32'(left_sample), 32'h000001);
`else
      check("starve_left", 32'(left_sample), 32'h000000);
`endif

      // Reset in the middle of a frame at bit position 40
      d_v0 = 1'b1; d_l0 = 24'h55AA55; d_r0 = 24'hAA55AA;
      for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
         if (m_k >= FRAME_CLKS && bit_pos(m_k) == 40) break;
         run_cycle();
      end
      check("pre_rst_pos", bit_pos(m_k), 32'd40);
      d_nrst = 1'b0;
      run_cycle();
      check("midrst_bclk",  32'(BCLK),           32'd0);
      check("midrst_lrclk", 32'(LRCLK),          32'd1);
      check("midrst_left",  32'(left_sample),    32'd0);
      check("midrst_count", 32'(underrun_count), 32'd0);
      d_nrst = 1'b1;
      repeat (2 * FRAME_CLKS) run_cycle();

      // Randomized sources with occasional enable drops
      for (int i = 0; i < 12 * FRAME_CLKS; i++) begin
         d_v0 = 1'($urandom_range(0, 1));
         d_v1 = 1'($urandom_range(0, 3) == 0);
         d_l0 = 24'($urandom); d_r0 = 24'($urandom);
         d_l1 = 24'($urandom); d_r1 = 24'($urandom);
         d_en = ($urandom_range(0, 399) != 0);
         run_cycle();
      end
      d_en = 1'b1;

      // Long starvation saturates the counter
      d_v0 = 1'b0; d_v1 = 1'b0;
      do_reset();
      repeat (270 * FRAME_CLKS) run_cycle();
      check("sat_underruns", 32'(underrun_count), 32'd255);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
